// File: rtl/seq_divider_core_pkg.sv
// Shared constants for the sequential restoring divider: default width,
// operand/result field offsets and FSM state encoding.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 48;

    // Field offsets inside the 2*W-bit operand and result words (default width)
    localparam int unsigned DIVIDEND_LSB = DIV_WIDTH;
    localparam int unsigned DIVISOR_LSB  = 0;
    localparam int unsigned QUOT_LSB     = DIV_WIDTH;
    localparam int unsigned REM_LSB      = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/seq_divider_core_step.sv
// One radix-2 restoring division iteration: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, keep or restore.
module div_step #(
    parameter int unsigned WIDTH = div_pkg::DIV_WIDTH
) (
    input  logic [WIDTH:0]   r,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_next,
    output logic             q_bit
);

    logic [WIDTH:0] r_shift;
    logic [WIDTH:0] d_ext;
    logic [WIDTH:0] diff;

    // Shift-compare-subtract; the top remainder bit is shifted out
    always_comb begin
        r_shift = (r << 1) | {{WIDTH{1'b0}}, q_msb};
        d_ext   = {1'b0, d};
        diff    = r_shift - d_ext;
        q_bit   = (r_shift >= d_ext);
        r_next  = q_bit ? diff : r_shift;
    end

endmodule

// File: rtl/seq_divider_core.sv
// Iterative unsigned divider: one quotient bit per cycle, result strobed
// once per operation, with sticky divide-by-zero and dropped-start counter.
module seq_divider_core
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 divider_clk,
    input  logic                 rst,
    input  logic                 op_valid,
    input  logic [2*WIDTH-1:0]   op_data,
    output logic                 res_valid,
    output logic [2*WIDTH-1:0]   res_data,
    output logic                 busy,
    output logic                 div_by_zero,
    output logic [CNT_W-1:0]     dropped_ops
);

    // Package offsets are expressed for the default width; rescale to WIDTH
    localparam int unsigned DVD_LSB = (DIVIDEND_LSB / DIV_WIDTH) * WIDTH;
    localparam int unsigned DVS_LSB = (DIVISOR_LSB  / DIV_WIDTH) * WIDTH;
    localparam int unsigned QT_LSB  = (QUOT_LSB     / DIV_WIDTH) * WIDTH;
    localparam int unsigned RM_LSB  = (REM_LSB      / DIV_WIDTH) * WIDTH;
    localparam int unsigned CTR_W   = $clog2(WIDTH + 1);

    div_state_t          state;
    logic                op_valid_q;
    logic                start;
    logic [WIDTH-1:0]    q_reg;
    logic [WIDTH-1:0]    d_reg;
    logic [WIDTH:0]      r_reg;
    logic [CTR_W-1:0]    iter_cnt;
    logic [WIDTH:0]      r_next;
    logic                q_bit;

    assign start = op_valid & ~op_valid_q;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r      (r_reg),
        .q_msb  (q_reg[WIDTH-1]),
        .d      (d_reg),
        .r_next (r_next),
        .q_bit  (q_bit)
    );

    // Control FSM, datapath registers, edge detect and status outputs
    always_ff @(posedge divider_clk) begin
        if (rst) begin
            state       <= IDLE;
            op_valid_q  <= 1'b0;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            iter_cnt    <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            busy        <= 1'b0;
            div_by_zero <= 1'b0;
            dropped_ops <= '0;
        end else begin
            op_valid_q <= op_valid;
            res_valid  <= 1'b0;

            if (start && state != IDLE && dropped_ops != '1) begin
                dropped_ops <= dropped_ops + 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        q_reg    <= op_data[DVD_LSB +: WIDTH];
                        d_reg    <= op_data[DVS_LSB +: WIDTH];
                        r_reg    <= '0;
                        iter_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    r_reg    <= r_next;
                    q_reg    <= {q_reg[WIDTH-2:0], q_bit};
                    iter_cnt <= iter_cnt + 1'b1;
                    if (iter_cnt == CTR_W'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    res_data[QT_LSB +: WIDTH] <= q_reg;
                    res_data[RM_LSB +: WIDTH] <= r_reg[WIDTH-1:0];
                    res_valid <= 1'b1;
                    busy      <= 1'b0;
                    if (d_reg == '0) begin
                        div_by_zero <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_core.sv
// Directed bench for seq_divider_core: hand-computed quotient/remainder
// vectors, latency, strobe handling, overrun counting and reset abort.
module tb_seq_divider_core;

    localparam int unsigned W = 48;
    localparam int unsigned C = 8;
    localparam logic [W-1:0] ALL1 = '1;

    logic             divider_clk = 1'b0;
    logic             rst = 1'b1;
    logic             op_valid = 1'b0;
    logic [2*W-1:0]   op_data = '0;
    logic             res_valid;
    logic [2*W-1:0]   res_data;
    logic             busy;
    logic             div_by_zero;
    logic [C-1:0]     dropped_ops;

    int vectors = 0;
    int miscompares = 0;

    seq_divider_core #(
        .WIDTH (W),
        .CNT_W (C)
    ) dut (
        .divider_clk (divider_clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .op_data     (op_data),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .busy        (busy),
        .div_by_zero (div_by_zero),
        .dropped_ops (dropped_ops)
    );

    always #5 divider_clk = ~divider_clk;

    task automatic tick();
        @(posedge divider_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Launch one operation and wait (bounded) for its result strobe.
    // hold: cycles op_valid stays high; inject_at: extra rising edge after that edge.
    task automatic do_op(input logic [2*W-1:0] opd, input int hold, input int inject_at,
                         output logic [2*W-1:0] res, output int lat, output int bcnt,
                         output bit got);
        op_data  = opd;
        op_valid = 1'b1;
        lat = 0; bcnt = 0; got = 1'b0; res = '0;
        for (int i = 1; i <= 150; i++) begin
            tick();
            if (i == hold) op_valid = 1'b0;
            if (inject_at > 0 && i == inject_at) op_valid = 1'b1;
            if (inject_at > 0 && i == inject_at + 1) op_valid = 1'b0;
            if (busy) bcnt++;
            if (res_valid) begin
                lat = i; res = res_data; got = 1'b1;
                break;
            end
        end
        op_valid = 1'b0;
    endtask

    task automatic count_pulses(input int n, output int p);
        p = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (res_valid) p++;
        end
    endtask

    logic [2*W-1:0] res;
    int lat, bcnt, pulses;
    bit got;
    logic [63:0] rnd;
    logic [W-1:0] dvd, dvs;

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_busy", busy, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_dropped", dropped_ops, 0);

        // 100 / 7 = 14 r 2, with latency and busy length
        do_op({48'd100, 48'd7}, 1, 0, res, lat, bcnt, got);
        check("basic_got", got, 1);
        check("basic_res", res, {48'd14, 48'd2});
        check("basic_latency", lat, 50);
        check("basic_busy_cycles", bcnt, 49);
        tick();
        check("basic_single_pulse", res_valid, 0);
        check("basic_res_hold", res_data, {48'd14, 48'd2});

        do_op({ALL1, 48'd1}, 1, 0, res, lat, bcnt, got);
        check("max_by_one", res, {ALL1, 48'd0});
        do_op({48'd5, 48'd9}, 1, 0, res, lat, bcnt, got);
        check("small_by_large", res, {48'd0, 48'd5});
        check("no_dbz_yet", div_by_zero, 0);

        // Divide by zero, then sticky flag across a normal op
        do_op({48'd1234, 48'd0}, 1, 0, res, lat, bcnt, got);
        check("dbz_res", res, {ALL1, 48'd1234});
        check("dbz_flag", div_by_zero, 1);
        do_op({48'd10, 48'd3}, 1, 0, res, lat, bcnt, got);
        check("after_dbz_res", res, {48'd3, 48'd1});
        check("dbz_sticky", div_by_zero, 1);

        // Held strobe: one start only
        do_op({48'd77, 48'd8}, 4, 0, res, lat, bcnt, got);
        check("held_res", res, {48'd9, 48'd5});
        count_pulses(60, pulses);
        check("held_one_result", pulses, 0);
        check("held_no_drop", dropped_ops, 0);

        // Second edge 10 cycles into the op is dropped
        do_op({48'd1000, 48'd33}, 1, 10, res, lat, bcnt, got);
        check("overrun_res", res, {48'd30, 48'd10});
        check("overrun_latency", lat, 50);
        check("overrun_dropped", dropped_ops, 1);
        count_pulses(60, pulses);
        check("overrun_no_extra", pulses, 0);

        // 300 rising edges: most land while busy, counter saturates
        op_data = {48'd500, 48'd3};
        for (int k = 0; k < 600; k++) begin
            op_valid = ~op_valid;
            tick();
        end
        op_valid = 1'b0;
        repeat (60) tick();
        check("dropped_saturated", dropped_ops, 255);
        check("sat_idle", busy, 0);

        // Reset mid-operation
        op_data  = {48'd100, 48'd7};
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        repeat (19) tick();
        check("midop_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_res_valid", res_valid, 0);
        check("abort_res_data", res_data, 0);
        check("abort_busy", busy, 0);
        check("abort_dbz", div_by_zero, 0);
        check("abort_dropped", dropped_ops, 0);
        count_pulses(60, pulses);
        check("abort_no_result", pulses, 0);
        do_op({48'd81, 48'd9}, 1, 0, res, lat, bcnt, got);
        check("post_abort_res", res, {48'd9, 48'd0});
        check("post_abort_latency", lat, 50);

        // Mixed pairs checked against the bench's own / and %
        for (int n = 0; n < 120; n++) begin
            rnd = {$urandom(), $urandom()};
            dvd = rnd[W-1:0];
            rnd = {$urandom(), $urandom()};
            case (n % 4)
                0: dvs = 48'd1;
                1: begin
                    dvd = W'($urandom_range(0, 5000));
                    dvs = dvd + W'($urandom_range(1, 100));
                end
                2: dvs = (rnd[W-1:0] == '0) ? 48'd1 : rnd[W-1:0];
                default: dvs = W'($urandom_range(1, 65535));
            endcase
            do_op({dvd, dvs}, 1, 0, res, lat, bcnt, got);
            check($sformatf("rand%0d_got", n), got, 1);
            check($sformatf("rand%0d_res", n), res, {dvd / dvs, dvd % dvs});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
